// File: rtl/unidade_load_store.sv
// Load/store unit: RISC-V b/h/w/d loads and stores against a synchronous-read
// 64-bit data memory. Sub-doubleword stores are done as read-modify-write.
module unidade_load_store #(
  parameter int unsigned ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [63:0]          req_addr,
  input  logic [63:0]          req_wdata,
  output logic                 resp_valid,
  output logic [63:0]          resp_rdata,
  output logic                 resp_err,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_we,
  output logic [63:0]          mem_din,
  input  logic [63:0]          mem_dout
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

  state_t      state, state_next;
  logic [2:0]  off_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [63:0] wdata_q;
  logic        accept;
  logic        bad;
  logic [5:0]  shamt;
  logic [63:0] shifted;
  logic [63:0] load_val;
  logic [63:0] mask;
  logic [63:0] mask_sh;
  logic [63:0] merged;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^req_addr[63:ADDR_BITS+3];

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_we     = (state == WRITE);
  assign accept     = req_valid && req_ready;

  // Illegal size codes and misaligned addresses are rejected before any memory access.
  always_comb begin
    bad = 1'b0;
    if (req_funct3 == 3'b111 || (req_we && req_funct3[2])) bad = 1'b1;
    case (req_funct3[1:0])
      2'b01:   if (req_addr[0])          bad = 1'b1;
      2'b10:   if (req_addr[1:0] != '0)  bad = 1'b1;
      2'b11:   if (req_addr[2:0] != '0)  bad = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bad)                                   state_next = RESP;
          else if (req_we && req_funct3[1:0] == 2'b11) state_next = WRITE;
          else                                       state_next = READ;
        end
      end
      READ:    state_next = WAIT;
      WAIT:    state_next = we_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign shamt   = {off_q, 3'b000};
  assign shifted = mem_dout >> shamt;

  always_comb begin
    load_val = '0;
    case (f3_q)
      3'b000:  load_val = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_val = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  load_val = shifted;
      3'b100:  load_val = {56'd0, shifted[7:0]};
      3'b101:  load_val = {48'd0, shifted[15:0]};
      3'b110:  load_val = {32'd0, shifted[31:0]};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    mask = '1;
    case (f3_q[1:0])
      2'b00:   mask = 64'h0000_0000_0000_00FF;
      2'b01:   mask = 64'h0000_0000_0000_FFFF;
      2'b10:   mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = '1;
    endcase
  end

  assign mask_sh = mask << shamt;
  assign merged  = (mem_dout & ~mask_sh) | ((wdata_q << shamt) & mask_sh);

  // Store data goes to mem_din at acceptance (used directly by sd); RMW stores
  // overwrite it with the merged doubleword while in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      off_q      <= '0;
      f3_q       <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        off_q    <= req_addr[2:0];
        f3_q     <= req_funct3;
        we_q     <= req_we;
        wdata_q  <= req_wdata;
        mem_addr <= req_addr[ADDR_BITS+2:3];
        if (req_we) mem_din <= req_wdata;
        if (bad) begin
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end
      end
      if (state == WAIT) begin
        if (we_q) begin
          mem_din <= merged;
        end else begin
          resp_rdata <= load_val;
          resp_err   <= 1'b0;
        end
      end
      if (state == WRITE) begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_unidade_load_store.sv
// Directed bench for unidade_load_store with a synchronous-read memory model.
module tb_unidade_load_store;

  localparam int unsigned AB = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [63:0]   req_addr = '0;
  logic [63:0]   req_wdata = '0;
  logic          resp_valid;
  logic [63:0]   resp_rdata;
  logic          resp_err;
  logic [AB-1:0] mem_addr;
  logic          mem_we;
  logic [63:0]   mem_din;
  logic [63:0]   mem_dout;

  logic [63:0]   mem [32];
  logic          pre_en = 1'b0;
  logic [AB-1:0] pre_idx = '0;
  logic [63:0]   pre_data = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_count = 0;
  int we_cyc = 0;
  logic [AB-1:0] we_idx = '0;
  logic [63:0]   we_din = '0;

  unidade_load_store #(.ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pre_en)      mem[pre_idx] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_we) begin
      we_count = we_count + 1;
      we_cyc   = cyc;
      we_idx   = mem_addr;
      we_din   = mem_din;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AB-1:0] idx, input logic [63:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Returns the acceptance cycle and the number of cycles until resp_valid (-1 on timeout).
  task automatic issue(input logic we, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, output int c0, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    c0 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = cyc - c0;
        break;
      end
    end
    chk("resp_timeout", 64'(lat == -1), 64'd0);
  endtask

  int c0, lat, wc;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_din", mem_din, 64'd0);
    rst = 1'b0;

    preload(5'd2, 64'h1122334455667788);
    issue(1'b0, 3'b000, 64'h17, 64'd0, c0, lat);
    chk("lb_lat", 64'(lat), 64'd3);
    chk("lb_data", resp_rdata, 64'h0000000000000011);
    chk("lb_err", 64'(resp_err), 64'd0);

    preload(5'd2, 64'h80FF000000000000);
    issue(1'b0, 3'b001, 64'h16, 64'd0, c0, lat);
    chk("lh_data", resp_rdata, 64'hFFFFFFFFFFFF80FF);
    issue(1'b0, 3'b101, 64'h16, 64'd0, c0, lat);
    chk("lhu_data", resp_rdata, 64'h00000000000080FF);
    issue(1'b0, 3'b100, 64'h16, 64'd0, c0, lat);
    chk("lbu_data", resp_rdata, 64'h00000000000000FF);

    preload(5'd1, 64'd0);
    wc = we_count;
    issue(1'b1, 3'b010, 64'h0C, 64'h00000000DEADBEEF, c0, lat);
    chk("sw_lat", 64'(lat), 64'd4);
    chk("sw_we_count", 64'(we_count - wc), 64'd1);
    chk("sw_we_idx", 64'(we_idx), 64'd1);
    chk("sw_we_din", we_din, 64'hDEADBEEF00000000);
    chk("sw_rdata", resp_rdata, 64'd0);
    issue(1'b0, 3'b011, 64'h08, 64'd0, c0, lat);
    chk("ld_after_sw", resp_rdata, 64'hDEADBEEF00000000);
    chk("ld_lat", 64'(lat), 64'd3);

    wc = we_count;
    issue(1'b1, 3'b011, 64'h18, 64'hA5A5A5A5A5A5A5A5, c0, lat);
    chk("sd_lat", 64'(lat), 64'd2);
    chk("sd_we_count", 64'(we_count - wc), 64'd1);
    chk("sd_we_cyc", 64'(we_cyc - c0), 64'd1);
    chk("sd_we_idx", 64'(we_idx), 64'd3);
    chk("sd_we_din", we_din, 64'hA5A5A5A5A5A5A5A5);
    issue(1'b0, 3'b011, 64'h18, 64'd0, c0, lat);
    chk("ld_after_sd", resp_rdata, 64'hA5A5A5A5A5A5A5A5);

    wc = we_count;
    issue(1'b0, 3'b010, 64'h0A, 64'd0, c0, lat);
    chk("lw_mis_lat", 64'(lat), 64'd1);
    chk("lw_mis_err", 64'(resp_err), 64'd1);
    chk("lw_mis_rdata", resp_rdata, 64'd0);
    issue(1'b1, 3'b100, 64'h08, 64'h55, c0, lat);
    chk("sbu_ill_err", 64'(resp_err), 64'd1);
    chk("sbu_ill_lat", 64'(lat), 64'd1);
    issue(1'b0, 3'b111, 64'h08, 64'd0, c0, lat);
    chk("f3_111_err", 64'(resp_err), 64'd1);
    chk("err_no_we", 64'(we_count - wc), 64'd0);

    // Reset while an sh is in WAIT must leave memory untouched.
    preload(5'd4, 64'h0123456789ABCDEF);
    wc = we_count;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 64'h20; req_wdata = 64'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 64'(req_ready), 64'd1);
    chk("abort_mem_we", 64'(mem_we), 64'd0);
    wc = wc + 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_resp", 64'(resp_valid), 64'd0);
    end
    chk("abort_no_write", 64'(we_count - wc), 64'd0);
    issue(1'b0, 3'b011, 64'h20, 64'd0, c0, lat);
    chk("abort_mem_kept", resp_rdata, 64'h0123456789ABCDEF);

    issue(1'b1, 3'b000, 64'h21, 64'h00000000000000AA, c0, lat);
    chk("sb_we_din", we_din, 64'h0123456789ABAAEF);
    issue(1'b0, 3'b000, 64'h21, 64'd0, c0, lat);
    chk("lb_neg", resp_rdata, 64'hFFFFFFFFFFFFFFAA);
    issue(1'b0, 3'b110, 64'h24, 64'd0, c0, lat);
    chk("lwu_hi", resp_rdata, 64'h0000000001234567);
    issue(1'b0, 3'b010, 64'h20, 64'd0, c0, lat);
    chk("lw_neg", resp_rdata, 64'hFFFFFFFF89ABAAEF);
    @(negedge clk);
    chk("resp_one_cycle", 64'(resp_valid), 64'd0);
    chk("rdata_hold", resp_rdata, 64'hFFFFFFFF89ABAAEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/unidade_load_store.md
UNIDADE_LOAD_STORE -- requirements
Module: unidade_load_store

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 5, giving the doubleword index width (2^ADDR_BITS x 64-bit data memory).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port req_valid, input, 1, core presents a load/store request.
REQ-005 The block SHALL have port req_ready, output, 1, block can accept a request.
REQ-006 The block SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-007 The block SHALL have port req_funct3, input, 3, RISC-V size/sign code: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
REQ-008 The block SHALL have port req_addr, input, 64, byte address (the ULA result).
REQ-009 The block SHALL have port req_wdata, input, 64, store data, right-justified.
REQ-010 The block SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have port resp_rdata, output, 64, load result, extended to 64 bits; 0 for stores and errors.
REQ-012 The block SHALL have port resp_err, output, 1, request was misaligned or illegal; valid with resp_valid.
REQ-013 The block SHALL have port mem_addr, output, ADDR_BITS, doubleword index to the data memory.
REQ-014 The block SHALL have port mem_we, output, 1, data memory write enable.
REQ-015 The block SHALL have port mem_din, output, 64, data memory write data.
REQ-016 The block SHALL have port mem_dout, input, 64, data memory read data; valid one cycle after mem_addr is presented.

Function
REQ-017 req_ready SHALL be 1 only in state IDLE; a request is accepted on a clk edge with req_valid=1 and req_ready=1, and addr, we, funct3, wdata are registered then.
REQ-018 The FSM SHALL use states IDLE, READ, WAIT, WRITE, RESP.
REQ-019 The registered index mem_addr SHALL be req_addr[ADDR_BITS+2:3]; upper address bits are ignored; byte offset is req_addr[2:0], little-endian.
REQ-020 Illegal request (funct3=111, or store with funct3 100/101/110) or misalignment (h: addr[0]!=0; w/wu: addr[1:0]!=0; d: addr[2:0]!=0) SHALL go IDLE->RESP with no memory access, resp_err=1, resp_rdata=0.
REQ-021 Legal load SHALL sequence IDLE->READ->WAIT->RESP; resp_valid is asserted 3 cycles after acceptance.
REQ-022 In WAIT the selected byte/half/word of mem_dout SHALL be shifted down by offset and sign-extended (b,h,w) or zero-extended (bu,hu,wu); d passes unchanged; the result is latched into resp_rdata.
REQ-023 Legal store of b/h/w SHALL sequence IDLE->READ->WAIT->WRITE->RESP (read-modify-write); in WAIT mem_din is formed by replacing only the addressed bytes of mem_dout with the low bytes of req_wdata; resp_valid 4 cycles after acceptance.
REQ-024 Legal store of d SHALL sequence IDLE->WRITE->RESP with mem_din=req_wdata; resp_valid 2 cycles after acceptance.
REQ-025 mem_we SHALL be 1 only in state WRITE, for exactly one cycle per store; mem_addr holds the request's index from READ through WRITE.
REQ-026 RESP SHALL last one cycle with resp_valid=1, then return to IDLE; resp_rdata and resp_err hold until the next RESP.
REQ-027 A request presented while req_ready=0 SHALL be ignored; the core must hold it until accepted.
REQ-028 Back-to-back requests SHALL be supported: a new request may be accepted the cycle after RESP; a load following a store to the same doubleword returns the stored data.

Reset
REQ-029 With rst=1 at a clk edge the FSM SHALL enter IDLE; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_din=0.
REQ-030 rst asserted mid-operation (including WRITE) SHALL abort the request with no response; mem_we is 0 from the reset edge onward, and memory contents are not cleared.

Verification
REQ-031 Memory[2]=0x1122334455667788; load lb at addr 0x17 -> resp_valid 3 cycles later, resp_rdata=0x0000000000000011, resp_err=0.
REQ-032 Memory[2]=0x80FF000000000000; load lh at 0x16 -> 0xFFFFFFFFFFFF80FF; lhu at 0x16 -> 0x00000000000080FF.
REQ-033 Memory[1]=0; store sw 0xDEADBEEF at 0x0C -> one mem_we pulse at index 1 with mem_din=0xDEADBEEF00000000; subsequent ld at 0x08 returns 0xDEADBEEF00000000.
REQ-034 store sd 0xA5A5A5A5A5A5A5A5 at 0x18 -> no READ state, mem_we 1 cycle after acceptance at index 3, resp_valid 2 cycles after acceptance.
REQ-035 lw at 0x0A -> resp_valid 1 cycle after acceptance, resp_err=1, resp_rdata=0, mem_we never asserted.
REQ-036 sh accepted, rst pulsed in WAIT -> no mem_we, no resp_valid, req_ready=1 the cycle after reset; memory unchanged.
